wb_arbiter: RTL
===============

Name: wb_arbiter

Overview:
- Writeback arbiter that drives the integer register file write port (RD/WR/RWR_EN).
- Merges two result sources:
  - the single-cycle ALU path;
  - the variable-latency load/store path (LSU), buffered in a small FIFO.
- Produces at most one register write per cycle, with registered outputs.
- Guarantees per-register write ordering and bounded LSU starvation.

Parameters:
- XLEN, 32, data width of write value.
- DEPTH, 2, LSU result FIFO entries (power of 2, >=2).
- STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO head may lose arbitration before it is forced.

Ports:
- clk_i  in  1  clock
- wbrst_i  in  1  synchronous reset, active high
- alu_valid_i  in  1  ALU result valid
- alu_rd_i  in  5  ALU destination register
- alu_data_i  in  XLEN  ALU result
- alu_ready_o  out  1  ALU result accepted this cycle when high with valid
- lsu_valid_i  in  1  LSU result valid
- lsu_rd_i  in  5  LSU destination register
- lsu_data_i  in  XLEN  LSU result
- lsu_ready_o  out  1  LSU result accepted this cycle when high with valid
- RD_o  out  5  register file write address
- WR_o  out  XLEN  register file write data
- RWR_EN_o  out  1  register file write enable
- fifo_count_o  out  $clog2(DEPTH+1)  LSU FIFO occupancy
- busy_o  out  1  FIFO non-empty or RWR_EN_o high

Behaviour:
- Reset is synchronous, active high. On the reset edge:
  - RD_o=0, WR_o=0, RWR_EN_o=0;
  - FIFO emptied, so fifo_count_o=0;
  - wait_cnt=0.
- Reset asserted mid-operation discards buffered LSU results; none are written.
- Handshakes are valid/ready; a transfer occurs on the edge where both are high. Valid must be held with stable payload until accepted.
- LSU path:
  - lsu_ready_o = (count < DEPTH), from registered state only.
  - No same-cycle full-pop pass-through.
  - Every accepted LSU result is pushed into the FIFO.
  - Push and pop in the same cycle leaves count unchanged.
- hazard = alu_valid_i && alu_rd_i!=0 && alu_rd_i equals the rd of any valid FIFO entry.
- starve = FIFO non-empty && wait_cnt >= STARVE_LIMIT.
- alu_ready_o = !starve && !hazard (combinational).
- Grant each cycle:
  - grant_alu = alu_valid_i && alu_ready_o.
  - grant_lsu = FIFO non-empty && !grant_alu (pops head).
- Output register update each edge:
  - if grant_alu: RD_o<=alu_rd_i, WR_o<=alu_data_i, RWR_EN_o<=(alu_rd_i!=0);
  - else if grant_lsu: RD_o<=head.rd, WR_o<=head.data, RWR_EN_o<=(head.rd!=0);
  - else RWR_EN_o<=0; RD_o/WR_o hold.
- rd==0: handshake or pop completes normally; the write is suppressed.
- Latency:
  - ALU accepted in cycle N: write visible in cycle N+1.
  - LSU accepted in cycle N with no contention: write in cycle N+2.
- wait_cnt:
  - 0 when the FIFO is empty or grant_lsu is high;
  - otherwise increments, saturating at STARVE_LIMIT.
- Ordering:
  - A younger ALU write never precedes an older buffered LSU write to the same nonzero rd (hazard stall).
  - LSU results write in FIFO order.

Decomposition:
- Package wb_pkg:
  - XLEN default;
  - typedef wb_req_t struct {logic [4:0] rd; logic [XLEN-1:0] data};
  - REG_ZERO = 5'd0.
- Sub-module wb_fifo:
  - synchronous DEPTH-entry FIFO of wb_req_t;
  - push/pop/full/empty/count outputs;
  - match_o = OR over valid entries of (entry.rd == cmp_rd_i && cmp_rd_i != 0).
- The top level holds arbitration, wait_cnt and the output registers.

Test Plan:
- Reset check: assert wbrst_i 2 cycles with valids high. Required: RWR_EN_o=0, RD_o=0, WR_o=0, fifo_count_o=0; after release lsu_ready_o=1, alu_ready_o=1.
- ALU only, cycle 1: alu rd=5, data=0xDEADBEEF. Required: cycle 2 RWR_EN_o=1, RD_o=5, WR_o=0xDEADBEEF; cycle 3 RWR_EN_o=0.
- LSU only:
  - lsu rd=7, data=0x00001234 in cycle 1: write x7 in cycle 3.
  - then lsu rd=0, data=0xFFFFFFFF: accepted, count returns to 0, RWR_EN_o never high for it.
- Starvation: ALU valid every cycle, rd=1 (unrelated); LSU pushes rd=9, data=0x99. Required: after 4 lost cycles, alu_ready_o=0 for exactly 1 cycle and x9 written; ALU writes resume next cycle.
- Hazard ordering: LSU rd=3, data=0xA buffered while ALU is busy; then ALU rd=3, data=0xB. Required: alu_ready_o=0 until the FIFO entry pops; write sequence x3=0xA then x3=0xB.
- Full and reset: DEPTH=2 with ALU saturating; 3 LSU pushes. Required: lsu_ready_o=0 after 2 accepts and fifo_count_o=2. Then assert wbrst_i: count=0, no LSU writes ever occur, lsu_ready_o=1 after release.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the integer writeback arbiter.
package wb_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small result FIFO for LSU writebacks, with a destination-register match port
// so younger ALU writes to a pending register can be held back.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  wb_req_t                    i_push_req,
    input  logic                       i_pop,
    input  logic [4:0]                 i_cmp_rd,
    output wb_req_t                    o_head_c,
    output logic                       o_full_c,
    output logic                       o_empty_c,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_match_c
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    wb_req_t         r_mem [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;

    assign o_full_c  = (r_count == CW'(DEPTH));
    assign o_empty_c = (r_count == '0);
    assign o_count   = r_count;
    assign o_head_c  = r_mem[r_rptr];
    assign w_push    = i_push && !o_full_c;
    assign w_pop     = i_pop && !o_empty_c;

    // Payload storage; entries are qualified by r_vld so no reset is needed.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_push_req;
        end
    end

    // Pointers, per-entry valid bits and occupancy.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_vld[r_rptr] <= 1'b0;
                r_rptr        <= r_rptr + AW'(1);
            end
            if (w_push) begin
                r_vld[r_wptr] <= 1'b1;
                r_wptr        <= r_wptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Any buffered entry targeting the compared (nonzero) register.
    always_comb begin
        o_match_c = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (r_mem[i].rd == i_cmp_rd) && (i_cmp_rd != REG_ZERO)) begin
                o_match_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the single-cycle ALU result and buffered LSU
// results onto the register-file write port, one registered write per cycle.
module wb_arbiter #(
    parameter int unsigned XLEN         = wb_pkg::XLEN,
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                       clk_i,
    input  logic                       wbrst_i,
    input  logic                       alu_valid_i,
    input  logic [4:0]                 alu_rd_i,
    input  logic [XLEN-1:0]            alu_data_i,
    output logic                       alu_ready_o,
    input  logic                       lsu_valid_i,
    input  logic [4:0]                 lsu_rd_i,
    input  logic [XLEN-1:0]            lsu_data_i,
    output logic                       lsu_ready_o,
    output logic [4:0]                 RD_o,
    output logic [XLEN-1:0]            WR_o,
    output logic                       RWR_EN_o,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count_o,
    output logic                       busy_o
);

    import wb_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned WW = $clog2(STARVE_LIMIT + 1);

    logic [WW-1:0]   r_wait_cnt;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_wr;
    logic            r_rwr_en;

    wb_req_t         w_push_req;
    wb_req_t         w_head;
    logic            w_full;
    logic            w_empty;
    logic [CW-1:0]   w_count;
    logic            w_match;
    logic            w_hazard;
    logic            w_starve;
    logic            w_grant_alu;
    logic            w_grant_lsu;
    logic            w_push;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk      (clk_i),
        .i_rst      (wbrst_i),
        .i_push     (w_push),
        .i_push_req (w_push_req),
        .i_pop      (w_grant_lsu),
        .i_cmp_rd   (alu_rd_i),
        .o_head_c   (w_head),
        .o_full_c   (w_full),
        .o_empty_c  (w_empty),
        .o_count    (w_count),
        .o_match_c  (w_match)
    );

    // Arbitration: ALU wins unless the LSU head has starved or the ALU would
    // overtake a buffered write to the same register.
    always_comb begin
        w_push_req.rd   = lsu_rd_i;
        w_push_req.data = lsu_data_i;
        w_hazard        = alu_valid_i && w_match;
        w_starve        = !w_empty && (r_wait_cnt >= WW'(STARVE_LIMIT));
        alu_ready_o     = !w_starve && !w_hazard;
        w_grant_alu     = alu_valid_i && alu_ready_o;
        w_grant_lsu     = !w_empty && !w_grant_alu;
        lsu_ready_o     = !w_full;
        w_push          = lsu_valid_i && lsu_ready_o;
    end

    // Write-port registers and the LSU starvation counter.
    always_ff @(posedge clk_i) begin
        if (wbrst_i) begin
            r_rd       <= '0;
            r_wr       <= '0;
            r_rwr_en   <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            if (w_grant_alu) begin
                r_rd     <= alu_rd_i;
                r_wr     <= alu_data_i;
                r_rwr_en <= (alu_rd_i != REG_ZERO);
            end else if (w_grant_lsu) begin
                r_rd     <= w_head.rd;
                r_wr     <= w_head.data;
                r_rwr_en <= (w_head.rd != REG_ZERO);
            end else begin
                r_rwr_en <= 1'b0;
            end

            if (w_empty || w_grant_lsu) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt < WW'(STARVE_LIMIT)) begin
                r_wait_cnt <= r_wait_cnt + WW'(1);
            end
        end
    end

    assign RD_o         = r_rd;
    assign WR_o         = r_wr;
    assign RWR_EN_o     = r_rwr_en;
    assign fifo_count_o = w_count;
    assign busy_o       = !w_empty || r_rwr_en;

endmodule
